msk_bit_framer: RTL and testbench
=================================

// Module: msk_bit_framer
// PURPOSE
//  Upstream bit source for the CPFSK/MSK modulator. Takes payload bytes over a valid/ready stream,
//  wraps them in preamble + sync word, serializes MSB-first at Rb = clk/CLK_PER_BIT (32 MHz/32 = 1 MHz)
//  and drives the modulator data input `din` (1 -> +0.25 MHz, 0 -> -0.25 MHz offset).
// PARAMETERS
//  CLK_PER_BIT     32        clocks per bit; min 2
//  PREAMBLE_BYTES  4         preamble length in bytes; 1..15
//  PREAMBLE_BYTE   8'h55     preamble pattern
//  SYNC_WORD       16'hEB90  sync word, sent MSB-first after preamble
//  IDLE_BIT        1'b0      din level while idle
// PORTS
//  clk        in   1  sample clock, 32 MHz
//  rst        in   1  synchronous reset, active high
//  s_data     in   8  payload byte
//  s_valid    in   1  s_data valid
//  s_last     in   1  byte is last of frame; qualified by s_valid
//  s_ready    out  1  holding register empty; byte taken when s_valid && s_ready
//  din        out  1  serial bit to modulator; held for CLK_PER_BIT clocks
//  bit_stb    out  1  one-clock pulse on first clock of each new bit period
//  busy       out  1  frame in progress (PREAMBLE/SYNC/PAYLOAD)
//  underrun   out  1  one-clock pulse when payload byte missing at byte boundary
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state IDLE, bit-clock counter 0, holding reg empty, s_ready=1,
//   din=IDLE_BIT, bit_stb=0, busy=0, underrun=0. Reset mid-frame aborts frame; held byte discarded.
//  Bit clock: counter free-runs 0..CLK_PER_BIT-1 in all states (NCO runs continuously); bit boundary
//   = cycle where counter wraps to 0. din/state/shift register change only on that cycle; bit_stb=1 there.
//  Holding register (1 byte) + shift register (8 bit) + bit index 0..7. s_ready = !hold_valid,
//   registered; accept -> s_ready falls next clock. Byte moves hold->shift only at a byte boundary in PAYLOAD.
//  FSM (transitions evaluated at bit boundaries only):
//   IDLE: din=IDLE_BIT. If hold_valid -> PREAMBLE; first preamble bit on this same boundary.
//   PREAMBLE: PREAMBLE_BYTES*8 bits of PREAMBLE_BYTE -> SYNC.
//   SYNC: 16 bits of SYNC_WORD -> PAYLOAD; first payload byte loaded from hold on final SYNC->PAYLOAD boundary.
//   PAYLOAD: shift MSB-first. At byte end: if current byte had last flag -> IDLE (din=IDLE_BIT next bit);
//    else if hold_valid -> load next; else load 8'h00 fill, pulse underrun, frame continues.
//  Latency: byte accepted in IDLE -> first preamble bit within <= CLK_PER_BIT clocks (next boundary).
//  Simultaneous: accept and hold->shift transfer on same clock allowed (hold refills same clock);
//   s_last stored with byte in hold. s_valid in IDLE with s_last=1 -> one-byte frame.
//  busy=1 from PREAMBLE entry boundary to the boundary returning to IDLE (exclusive).
// CONFIGURATION
//  DIFF_PRECODE_EN defined: din = b(n) XOR din(n-1) for every bit incl. preamble/sync; precoder
//   state cleared to 0 at reset and on IDLE->PREAMBLE; in IDLE din=IDLE_BIT, precoder not updated.
//  Not defined: din = raw framed bit; no precoder register.
// STRUCTURE
//  Package msk_pkg: state enum {IDLE,PREAMBLE,SYNC,PAYLOAD}, default PREAMBLE_BYTE/SYNC_WORD
//   constants, Rb/clock ratio constant (32).
//  Sub-module msk_bit_clock: free-running CLK_PER_BIT counter, outputs bit_stb. Rest in top level.
// TESTING
//  Reset then idle 100 clocks -> din=0, bit_stb every 32 clocks, s_ready=1, busy=0.
//  One byte 8'hA5 s_last=1 -> 32 bits 0x55, 16 bits 0xEB90, bits 1,0,1,0,0,1,0,1, then din=0, busy=0.
//  3 bytes 01,02,03 (last on 03) back-to-back -> contiguous payload, no underrun, s_ready drops 1 clk after accept.
//  Byte 8'hFF no last, then stall 20 bit times -> 0xFF, then 0x00 fills, underrun pulse at each empty boundary.
//  rst asserted mid-SYNC -> next clock din=0, busy=0, s_ready=1; new frame restarts full preamble.
//  DIFF_PRECODE_EN, frame byte 8'hFF -> payload din toggles each bit; check against XOR model from preamble start.

Source files
------------

// File: rtl/msk_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// msk_pkg
// Shared framer state encoding and default framing constants.
// Revision: 1.0
//------------------------------------------------------------------------------
package msk_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      SYNC     = 2'd2,
      PAYLOAD  = 2'd3
   } state_t;

   // 32 MHz sample clock over a 1 Mb/s bit rate
   localparam int RB_CLK_RATIO = 32;

   localparam logic [7:0]  DEF_PREAMBLE_BYTE = 8'h55;
   localparam logic [15:0] DEF_SYNC_WORD     = 16'hEB90;

   // wide enough for 15 preamble bytes (120 bits)
   localparam int PHASE_CNT_W = 7;

endpackage
`default_nettype wire

// File: rtl/msk_bit_clock.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// msk_bit_clock
// Free-running bit-rate counter; tick marks the last clock of a bit period.
// Revision: 1.0
//------------------------------------------------------------------------------
module msk_bit_clock
   import msk_pkg::*;
#(
   parameter int CLK_PER_BIT = RB_CLK_RATIO
) (
   input  logic clk,
   input  logic rst,
   output logic tick,
   output logic bit_stb
);

   localparam int              CNT_W   = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_MAX);

   // bit_stb lines up with the clock on which the framer's new bit appears
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         bit_stb <= 1'b0;
      end else begin
         cnt     <= tick ? '0 : cnt + 1'b1;
         bit_stb <= tick;
      end
   end

endmodule
`default_nettype wire

// File: rtl/msk_bit_framer.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// msk_bit_framer
// Wraps payload bytes in preamble + sync word and serializes MSB-first.
// Optional DIFF_PRECODE_EN enables differential precoding of din.
// Revision: 1.0
//------------------------------------------------------------------------------
module msk_bit_framer
   import msk_pkg::*;
#(
   parameter int          CLK_PER_BIT    = RB_CLK_RATIO,
   parameter int          PREAMBLE_BYTES = 4,
   parameter logic [7:0]  PREAMBLE_BYTE  = DEF_PREAMBLE_BYTE,
   parameter logic [15:0] SYNC_WORD      = DEF_SYNC_WORD,
   parameter logic        IDLE_BIT       = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic       din,
   output logic       bit_stb,
   output logic       busy,
   output logic       underrun
);

   localparam logic [PHASE_CNT_W-1:0] PRE_LAST  = PHASE_CNT_W'(PREAMBLE_BYTES * 8 - 1);
   localparam logic [PHASE_CNT_W-1:0] SYNC_LAST = PHASE_CNT_W'(15);
   localparam logic [PHASE_CNT_W-1:0] BYTE_LAST = PHASE_CNT_W'(7);

   state_t                 state, state_n;
   logic [PHASE_CNT_W-1:0] pcnt, pcnt_n, pcnt_inc;
   logic [7:0]             hold_data, shift, shift_n;
   logic                   hold_valid, hold_last, cur_last, cur_last_n;
   logic                   tick, raw_bit, out_bit, load, fill;

   msk_bit_clock #(.CLK_PER_BIT(CLK_PER_BIT)) u_bit_clock (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .bit_stb (bit_stb)
   );

   assign s_ready = !hold_valid;
   assign busy    = (state != IDLE);

   always_comb begin
      state_n    = state;
      pcnt_n     = pcnt;
      shift_n    = shift;
      cur_last_n = cur_last;
      raw_bit    = IDLE_BIT;
      load       = 1'b0;
      fill       = 1'b0;
      pcnt_inc   = pcnt + 1'b1;
      case (state)
         IDLE: begin
            if (hold_valid) begin
               state_n = PREAMBLE;
               pcnt_n  = '0;
               raw_bit = PREAMBLE_BYTE[7];
            end
         end
         PREAMBLE: begin
            if (pcnt == PRE_LAST) begin
               state_n = SYNC;
               pcnt_n  = '0;
               raw_bit = SYNC_WORD[15];
            end else begin
               pcnt_n  = pcnt_inc;
               raw_bit = PREAMBLE_BYTE[~pcnt_inc[2:0]];
            end
         end
         SYNC: begin
            if (pcnt == SYNC_LAST) begin
               state_n = PAYLOAD;
               pcnt_n  = '0;
               load    = 1'b1;
            end else begin
               pcnt_n  = pcnt_inc;
               raw_bit = SYNC_WORD[~pcnt_inc[3:0]];
            end
         end
         PAYLOAD: begin
            if (pcnt == BYTE_LAST) begin
               if (cur_last) begin
                  state_n = IDLE;
               end else begin
                  pcnt_n = '0;
                  load   = 1'b1;
               end
            end else begin
               pcnt_n  = pcnt_inc;
               shift_n = {shift[6:0], 1'b0};
               raw_bit = shift[6];
            end
         end
         default: state_n = IDLE;
      endcase
      // An empty holding register at a byte boundary sends a zero fill byte
      if (load) begin
         fill       = !hold_valid;
         shift_n    = hold_valid ? hold_data : 8'h00;
         cur_last_n = hold_valid & hold_last;
         raw_bit    = shift_n[7];
      end
   end

`ifdef DIFF_PRECODE_EN
   logic pre_state;
   logic frame_start;

   assign frame_start = (state == IDLE);
   assign out_bit     = (state_n == IDLE) ? IDLE_BIT
                                          : raw_bit ^ (frame_start ? 1'b0 : pre_state);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_state <= 1'b0;
      end else if (tick && (state_n != IDLE)) begin
         pre_state <= out_bit;
      end
   end
`else
   assign out_bit = raw_bit;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pcnt       <= '0;
         shift      <= '0;
         cur_last   <= 1'b0;
         hold_valid <= 1'b0;
         hold_data  <= '0;
         hold_last  <= 1'b0;
         din        <= IDLE_BIT;
         underrun   <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (tick) begin
            state    <= state_n;
            pcnt     <= pcnt_n;
            shift    <= shift_n;
            cur_last <= cur_last_n;
            din      <= out_bit;
            underrun <= fill;
         end
         if (s_valid && s_ready) begin
            hold_data  <= s_data;
            hold_last  <= s_last;
            hold_valid <= 1'b1;
         end else if (tick && load) begin
            hold_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_msk_bit_framer.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// tb_msk_bit_framer
// Randomized frames checked bit-by-bit against a queue-based frame model.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_msk_bit_framer;

   localparam int   CPB   = 32;
   localparam int   PRE_N = 4;
   localparam logic IDLE_LVL = 1'b0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       s_ready, din, bit_stb, busy, underrun;

   msk_bit_framer #(
      .CLK_PER_BIT    (CPB),
      .PREAMBLE_BYTES (PRE_N),
      .PREAMBLE_BYTE  (8'h55),
      .SYNC_WORD      (16'hEB90),
      .IDLE_BIT       (IDLE_LVL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .din      (din),
      .bit_stb  (bit_stb),
      .busy     (busy),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Monitor: bit period spacing and per-bit capture while a frame is active
   int cyc = 0;
   int last_stb = 0;
   int start_cyc = 0;
   int acc_cyc = 0;
   bit obs_din[$];
   bit obs_und[$];

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         last_stb = cyc + 1;
      end else begin
         if (bit_stb) begin
            check("stb_period", cyc - last_stb, CPB);
            last_stb = cyc;
            if (busy) begin
               if (obs_din.size() == 0) start_cyc = cyc;
               obs_din.push_back(din);
               obs_und.push_back(underrun);
            end
         end
         if (underrun) check("und_on_stb", bit_stb, 1);
      end
   end

   // Frame model built from the framing rules
   logic [7:0] exp_bytes[$];
   bit         exp_fill[$];
   bit         exp_din[$];
   bit         exp_und[$];

   task automatic build_model();
      logic [7:0]  pre = 8'h55;
      logic [15:0] sw  = 16'hEB90;
      exp_din.delete();
      exp_und.delete();
      for (int i = 0; i < PRE_N; i++)
         for (int k = 7; k >= 0; k--) begin
            exp_din.push_back(pre[k]);
            exp_und.push_back(1'b0);
         end
      for (int k = 15; k >= 0; k--) begin
         exp_din.push_back(sw[k]);
         exp_und.push_back(1'b0);
      end
      for (int j = 0; j < exp_bytes.size(); j++)
         for (int k = 7; k >= 0; k--) begin
            exp_din.push_back(exp_bytes[j][k]);
            exp_und.push_back(exp_fill[j] && (k == 7));
         end
`ifdef DIFF_PRECODE_EN
      begin
         bit prev = 1'b0;
         for (int i = 0; i < exp_din.size(); i++) begin
            exp_din[i] = exp_din[i] ^ prev;
            prev = exp_din[i];
         end
      end
`endif
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last, input bit first);
      int n = 0;
      @(posedge clk); #1;
      s_data  = d;
      s_last  = last;
      s_valid = 1'b1;
      @(negedge clk);
      while (!s_ready && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", n < 4000, 1);
      @(posedge clk); #1;
      if (first) acc_cyc = cyc;
      check("s_ready_drop", s_ready, 0);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // stall=1: send first byte, hold off the last until three fill bytes are due
   task automatic run_frame(input string name, input bit stall);
      int n = 0;
      int m = 0;
      int thr;
      int lat;
      obs_din.delete();
      obs_und.delete();
      build_model();
      thr = (PRE_N + 2) * 8 + 8 * (exp_bytes.size() - 2) + 3;
      fork
         begin
            if (!stall) begin
               for (int j = 0; j < exp_bytes.size(); j++) begin
                  send_byte(exp_bytes[j], j == exp_bytes.size() - 1, j == 0);
                  repeat ($urandom_range(0, 3)) @(posedge clk);
               end
            end else begin
               send_byte(exp_bytes[0], 1'b0, 1'b1);
               while (obs_din.size() < thr && m < 20000) begin
                  @(negedge clk);
                  m++;
               end
               send_byte(exp_bytes[exp_bytes.size() - 1], 1'b1, 1'b0);
            end
         end
         begin
            while (!busy && n < 400) begin
               @(negedge clk);
               n++;
            end
            while (busy && n < 20000) begin
               @(negedge clk);
               n++;
            end
         end
      join
      check({name, "_done"}, n < 20000, 1);
      check({name, "_end_din"}, din, IDLE_LVL);
      check({name, "_end_stb"}, bit_stb, 1);
      lat = start_cyc - acc_cyc - 1;
      check({name, "_latency"}, (lat >= 1) && (lat <= CPB), 1);
      check({name, "_nbits"}, obs_din.size(), exp_din.size());
      for (int i = 0; i < exp_din.size(); i++) begin
         if (i < obs_din.size()) begin
            check($sformatf("%s_din%0d", name, i), obs_din[i], exp_din[i]);
            check($sformatf("%s_und%0d", name, i), obs_und[i], exp_und[i]);
         end
      end
   endtask

   initial begin
      int bad_din, bad_busy, bad_rdy, k;
      #900000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      int bad_din, bad_busy, bad_rdy, k;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_din", din, IDLE_LVL);
      check("rst_busy", busy, 0);
      check("rst_ready", s_ready, 1);
      check("rst_stb", bit_stb, 0);
      check("rst_und", underrun, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      bad_din = 0; bad_busy = 0; bad_rdy = 0;
      repeat (100) begin
         @(negedge clk);
         if (din !== IDLE_LVL) bad_din++;
         if (busy !== 1'b0) bad_busy++;
         if (s_ready !== 1'b1) bad_rdy++;
      end
      check("idle_din", bad_din, 0);
      check("idle_busy", bad_busy, 0);
      check("idle_ready", bad_rdy, 0);

      exp_bytes = '{8'hA5};
      exp_fill  = '{1'b0};
      run_frame("a5", 1'b0);

      exp_bytes = '{8'h01, 8'h02, 8'h03};
      exp_fill  = '{1'b0, 1'b0, 1'b0};
      run_frame("b2b", 1'b0);

      exp_bytes = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h3C};
      exp_fill  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      run_frame("under", 1'b1);

      exp_bytes = '{8'hFF};
      exp_fill  = '{1'b0};
      run_frame("ff", 1'b0);

      // Abort a frame while the sync word is on the air
      obs_din.delete();
      obs_und.delete();
      send_byte(8'hA5, 1'b1, 1'b1);
      k = 0;
      while (obs_din.size() < 40 && k < 4000) begin
         @(negedge clk);
         k++;
      end
      check("sync_reach", k < 4000, 1);
      repeat ($urandom_range(1, 20)) @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_din", din, IDLE_LVL);
      check("abort_busy", busy, 0);
      check("abort_ready", s_ready, 1);
      check("abort_stb", bit_stb, 0);
      rst = 1'b0;
      exp_bytes = '{8'hA5};
      exp_fill  = '{1'b0};
      run_frame("restart", 1'b0);

      for (int f = 0; f < 4; f++) begin
         exp_bytes.delete();
         exp_fill.delete();
         for (int j = 0; j < $urandom_range(1, 4); j++) begin
            exp_bytes.push_back(8'($urandom));
            exp_fill.push_back(1'b0);
         end
         run_frame($sformatf("rnd%0d", f), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
